// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants for the F/D pipeline register: exception codes, reset/handler PCs
// and instruction-memory bounds.
package fd_pipe_reg_pkg;

  localparam logic [5:0] ExcNone = 6'd0;
  localparam logic [5:0] ExcAdel = 6'd4;
  localparam logic [5:0] ExcRi   = 6'd10;

  localparam logic [31:0] PcResetDefault   = 32'h0000_3000;
  localparam logic [31:0] PcHandlerDefault = 32'h0000_4180;
  localparam logic [31:0] ImLoDefault      = 32'h0000_3000;
  localparam logic [31:0] ImHiDefault      = 32'h0000_6ffc;

  localparam logic [31:0] InstrNop = 32'h0000_0000;

endpackage

// File: rtl/fd_pipe_reg_f_exc.sv
// Combinational fetch-address check: flags misaligned or out-of-range PCs as AdEL.
module f_exc
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] IM_LO = ImLoDefault,
  parameter logic [31:0] IM_HI = ImHiDefault
) (
  input  logic [31:0] pc_f,
  output logic [5:0]  exccode_f
);

  logic misaligned;
  logic out_of_range;

  // Unsigned compare, so a wrapped address such as 32'hffff_fffc falls above IM_HI.
  assign misaligned   = (pc_f[1:0] != 2'b00);
  assign out_of_range = (pc_f < IM_LO) || (pc_f > IM_HI);

  always_comb begin
    exccode_f = ExcNone;
    if (misaligned || out_of_range) begin
      exccode_f = ExcAdel;
    end
  end

endmodule

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register: samples fetch PC/instruction each enabled cycle and carries the
// fetch-stage exception code into decode.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PcResetDefault,
  parameter logic [31:0] PC_HANDLER = PcHandlerDefault,
  parameter logic [31:0] IM_LO      = ImLoDefault,
  parameter logic [31:0] IM_HI      = ImHiDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        exc_flush,
  input  logic        eret_clr,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic [5:0]  exccode_dl,
  output logic        bd_d
);

  logic [5:0]  exccode_f;
  logic [31:0] instr_fetched;

  f_exc #(
    .IM_LO (IM_LO),
    .IM_HI (IM_HI)
  ) u_f_exc (
    .pc_f      (pc_f),
    .exccode_f (exccode_f)
  );

  // A faulting fetch delivers a nop so decode never acts on garbage.
  assign instr_fetched = (exccode_f != ExcNone) ? InstrNop : instr_f;

  // Flush outranks stall; ERET clear is ignored while stalled since ERET stays in D.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d       <= PC_RESET;
      instr_d    <= InstrNop;
      exccode_dl <= ExcNone;
      bd_d       <= 1'b0;
    end else if (exc_flush) begin
      pc_d       <= PC_HANDLER;
      instr_d    <= InstrNop;
      exccode_dl <= ExcNone;
      bd_d       <= 1'b0;
    end else if (en) begin
      pc_d <= pc_f;
      if (eret_clr) begin
        instr_d    <= InstrNop;
        exccode_dl <= ExcNone;
        bd_d       <= 1'b0;
      end else begin
        instr_d    <= instr_fetched;
        exccode_dl <= exccode_f;
        bd_d       <= bd_f;
      end
    end
  end

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: hand-computed expectations checked with immediate assertions.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, en, exc_flush, eret_clr, bd_f;
  logic [31:0] pc_f, instr_f;
  logic [31:0] pc_d, instr_d;
  logic [5:0]  exccode_dl;
  logic        bd_d;

  int errors = 0;
  int checks = 0;

  fd_pipe_reg dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .exc_flush  (exc_flush),
    .eret_clr   (eret_clr),
    .pc_f       (pc_f),
    .instr_f    (instr_f),
    .bd_f       (bd_f),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .exccode_dl (exccode_dl),
    .bd_d       (bd_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic fl, input logic er,
                     input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    reset = r; en = e; exc_flush = fl; eret_clr = er;
    pc_f = pc; instr_f = ins; bd_f = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [5:0] exc, input logic bd);
    chk({tag, ".pc"}, pc_d, pc);
    chk({tag, ".instr"}, instr_d, ins);
    chk({tag, ".exc"}, {26'd0, exccode_dl}, {26'd0, exc});
    chk({tag, ".bd"}, {31'd0, bd_d}, {31'd0, bd});
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; exc_flush = 1'b0; eret_clr = 1'b0;
    pc_f = 32'h3008; instr_f = 32'hffff_ffff; bd_f = 1'b1;

    // Reset held for two cycles
    cyc(1, 1, 0, 0, 32'h3008, 32'hffff_ffff, 1);
    chk_all("reset1", 32'h3000, 32'h0, 6'd0, 0);
    cyc(1, 1, 0, 0, 32'h3008, 32'hffff_ffff, 1);
    chk_all("reset2", 32'h3000, 32'h0, 6'd0, 0);

    // Normal load
    cyc(0, 1, 0, 0, 32'h3004, 32'h2408_0001, 1);
    chk_all("load", 32'h3004, 32'h2408_0001, 6'd0, 1);

    // Address checks
    cyc(0, 1, 0, 0, 32'h3006, 32'hdead_beef, 0);
    chk_all("misalign", 32'h3006, 32'h0, 6'd4, 0);
    cyc(0, 1, 0, 0, 32'h7000, 32'hdead_beef, 1);
    chk_all("above_hi", 32'h7000, 32'h0, 6'd4, 1);
    cyc(0, 1, 0, 0, 32'h6ffc, 32'h1111_1111, 0);
    chk_all("at_hi", 32'h6ffc, 32'h1111_1111, 6'd0, 0);
    cyc(0, 1, 0, 0, 32'h2ffc, 32'h2222_2222, 0);
    chk_all("below_lo", 32'h2ffc, 32'h0, 6'd4, 0);
    cyc(0, 1, 0, 0, 32'h3000, 32'h3333_3333, 0);
    chk_all("at_lo", 32'h3000, 32'h3333_3333, 6'd0, 0);
    cyc(0, 1, 0, 0, 32'hffff_fffc, 32'h4444_4444, 0);
    chk_all("wrap", 32'hffff_fffc, 32'h0, 6'd4, 0);

    // Stall holds across changing inputs, including eret_clr
    cyc(0, 1, 0, 0, 32'h3010, 32'haaaa_0001, 1);
    chk_all("pre_stall", 32'h3010, 32'haaaa_0001, 6'd0, 1);
    cyc(0, 0, 0, 0, 32'h3014, 32'hbbbb_0002, 0);
    chk_all("stall1", 32'h3010, 32'haaaa_0001, 6'd0, 1);
    cyc(0, 0, 0, 1, 32'h3006, 32'hcccc_0003, 0);
    chk_all("stall2_eret", 32'h3010, 32'haaaa_0001, 6'd0, 1);
    cyc(0, 0, 0, 0, 32'h7000, 32'hdddd_0004, 0);
    chk_all("stall3", 32'h3010, 32'haaaa_0001, 6'd0, 1);

    // Flush beats stall
    cyc(0, 0, 1, 0, 32'h3018, 32'heeee_0005, 1);
    chk_all("flush_stall", 32'h4180, 32'h0, 6'd0, 0);

    // Reload a faulting fetch, then flush + eret together
    cyc(0, 1, 0, 0, 32'h3001, 32'h5555_5555, 1);
    chk_all("reload_adel", 32'h3001, 32'h0, 6'd4, 1);
    cyc(0, 1, 1, 1, 32'h3024, 32'h6666_6666, 1);
    chk_all("flush_eret", 32'h4180, 32'h0, 6'd0, 0);

    // ERET clear
    cyc(0, 1, 0, 1, 32'h3020, 32'h1234_5678, 1);
    chk_all("eret_clr", 32'h3020, 32'h0, 6'd0, 0);

    // Reset wins over stall and flush; load resumes right after
    cyc(0, 1, 0, 0, 32'h3028, 32'h7777_7777, 1);
    chk_all("pre_reset", 32'h3028, 32'h7777_7777, 6'd0, 1);
    cyc(1, 0, 1, 0, 32'h302c, 32'h8888_8888, 1);
    chk_all("reset_mid", 32'h3000, 32'h0, 6'd0, 0);
    cyc(0, 1, 0, 0, 32'h302c, 32'h8888_8888, 1);
    chk_all("post_reset", 32'h302c, 32'h8888_8888, 6'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
